// File: rtl/ama_riscv_perf_cnt.sv
// Performance-counter bank: one cycle counter plus NUM_EVT event counters.
// Live counters count in RUN and freeze on test halt. A shadow bank is
// captured on snap, and all reads are served from it so lo/hi halves
// stay coherent.
module ama_riscv_perf_cnt #(
    parameter int unsigned NUM_EVT  = 4,
    parameter int unsigned CNT_W    = 64,
    parameter int unsigned SATURATE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               cnt_en,
    input  logic               cnt_clear,
    input  logic               halt,
    input  logic               snap,
    input  logic               rd_en,
    input  logic [4:0]         rd_addr,
    output logic [31:0]        rd_data,
    output logic               rd_valid,
    output logic               rd_err,
    output logic [NUM_EVT:0]   ovf,
    output logic               frozen
);

    typedef enum logic [0:0] {StRun, StFrozen} state_e;

    state_e state_q, state_d;

    // Entry 0 is the cycle counter, entry i counts evt[i-1].
    logic [NUM_EVT:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_EVT:0][CNT_W-1:0] shadow_q, shadow_d;
    logic [NUM_EVT:0]            ovf_q, ovf_d;
    logic [NUM_EVT:0]            inc;
    logic                        count_on;

    logic [3:0]  rd_idx;
    logic        rd_hi;
    logic        rd_hit;
    logic [63:0] rd_sel;
    logic [31:0] rd_data_d;
    logic        rd_err_d;

    // State transition: clear has priority over halt while running.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:    if (halt && !cnt_clear) state_d = StFrozen;
            StFrozen: if (cnt_clear) state_d = StRun;
            default:  state_d = StRun;
        endcase
    end

    // Counter next-state: clear wins over any increment in the same cycle.
    always_comb begin
        count_on = (state_q == StRun) && cnt_en;
        inc      = {evt & {NUM_EVT{count_on}}, count_on};
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        if (cnt_clear) begin
            cnt_d = '0;
            ovf_d = '0;
        end else begin
            for (int unsigned i = 0; i <= NUM_EVT; i++) begin
                if (inc[i]) begin
                    if (cnt_q[i] == {CNT_W{1'b1}}) begin
                        ovf_d[i] = 1'b1;
                        if (SATURATE == 0) cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Shadow captures pre-increment, pre-clear live values.
    always_comb begin
        shadow_d = snap ? cnt_q : shadow_q;
    end

    // Read mux from the current (pre-snap) shadow; out-of-range idx flags an error.
    always_comb begin
        rd_idx    = rd_addr[4:1];
        rd_hi     = rd_addr[0];
        rd_sel    = '0;
        rd_hit    = 1'b0;
        rd_data_d = '0;
        rd_err_d  = 1'b0;
        for (int unsigned i = 0; i <= NUM_EVT; i++) begin
            if (rd_idx == 4'(i)) begin
                rd_sel = 64'(shadow_q[i]);
                rd_hit = 1'b1;
            end
        end
        if (rd_en) begin
            if (!rd_hit) rd_err_d = 1'b1;
            else         rd_data_d = rd_hi ? rd_sel[63:32] : rd_sel[31:0];
        end
    end

    // State, counters, shadow and read response registers; reset dominates.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRun;
            cnt_q    <= '0;
            shadow_q <= '0;
            ovf_q    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_err   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            ovf_q    <= ovf_d;
            rd_data  <= rd_data_d;
            rd_valid <= rd_en;
            rd_err   <= rd_err_d;
        end
    end

    assign ovf    = ovf_q;
    assign frozen = (state_q == StFrozen);

endmodule

// File: tb/tb_ama_riscv_perf_cnt.sv
// Directed bench for ama_riscv_perf_cnt: a 64-bit wrapping bank plus 32-bit
// wrapping and saturating banks driven by the same stimulus.
module tb_ama_riscv_perf_cnt;

    localparam int unsigned NUM_EVT = 4;

    logic               clk;
    logic               rst;
    logic [NUM_EVT-1:0] evt;
    logic               cnt_en;
    logic               cnt_clear;
    logic               halt;
    logic               snap;
    logic               rd_en;
    logic [4:0]         rd_addr;

    logic [31:0]        rd_data,  rd_data_w,  rd_data_s;
    logic               rd_valid, rd_valid_w, rd_valid_s;
    logic               rd_err,   rd_err_w,   rd_err_s;
    logic [NUM_EVT:0]   ovf,      ovf_w,      ovf_s;
    logic               frozen,   frozen_w,   frozen_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vecs[8];

    ama_riscv_perf_cnt #(.NUM_EVT(NUM_EVT), .CNT_W(64), .SATURATE(0)) dut (
        .clk(clk), .rst(rst), .evt(evt), .cnt_en(cnt_en), .cnt_clear(cnt_clear),
        .halt(halt), .snap(snap), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err), .ovf(ovf),
        .frozen(frozen)
    );

    ama_riscv_perf_cnt #(.NUM_EVT(NUM_EVT), .CNT_W(32), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .evt(evt), .cnt_en(cnt_en), .cnt_clear(cnt_clear),
        .halt(halt), .snap(snap), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_w), .rd_valid(rd_valid_w), .rd_err(rd_err_w), .ovf(ovf_w),
        .frozen(frozen_w)
    );

    ama_riscv_perf_cnt #(.NUM_EVT(NUM_EVT), .CNT_W(32), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .evt(evt), .cnt_en(cnt_en), .cnt_clear(cnt_clear),
        .halt(halt), .snap(snap), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_s), .rd_valid(rd_valid_s), .rd_err(rd_err_s), .ovf(ovf_s),
        .frozen(frozen_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are then sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Single read of the 64-bit bank, including the one-cycle valid pulse.
    task automatic rd_chk(input string name, input logic [3:0] idx, input logic hi,
                          input logic [31:0] exp, input logic exp_err);
        rd_en   = 1'b1;
        rd_addr = {idx, hi};
        tick();
        rd_en = 1'b0;
        check({name, " valid"}, 64'(rd_valid), 64'd1);
        check({name, " data"}, 64'(rd_data), 64'(exp));
        check({name, " err"}, 64'(rd_err), 64'(exp_err));
        tick();
        check({name, " valid drop"}, 64'(rd_valid), 64'd0);
    endtask

    // Issue one read to all banks; caller checks the responses.
    task automatic rd_all(input logic [3:0] idx, input logic hi);
        rd_en   = 1'b1;
        rd_addr = {idx, hi};
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse_snap();
        snap = 1'b1;
        tick();
        snap = 1'b0;
    endtask

    task automatic pulse_clear();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] p0;
        logic [9:0] p3;
        p0 = 10'b1001010010;  // 4 events on channel 1
        p3 = 10'b0111011101;  // 7 events on channel 4

        vecs[0] = '{addr: {4'd0, 1'b0}, data: 32'd10, err: 1'b0};
        vecs[1] = '{addr: {4'd0, 1'b1}, data: 32'd0,  err: 1'b0};
        vecs[2] = '{addr: {4'd1, 1'b0}, data: 32'd4,  err: 1'b0};
        vecs[3] = '{addr: {4'd1, 1'b1}, data: 32'd0,  err: 1'b0};
        vecs[4] = '{addr: {4'd2, 1'b0}, data: 32'd0,  err: 1'b0};
        vecs[5] = '{addr: {4'd4, 1'b0}, data: 32'd7,  err: 1'b0};
        vecs[6] = '{addr: {4'd5, 1'b0}, data: 32'd0,  err: 1'b1};
        vecs[7] = '{addr: {4'd15, 1'b1}, data: 32'd0, err: 1'b1};

        rst = 1'b1; evt = '0; cnt_en = 1'b0; cnt_clear = 1'b0;
        halt = 1'b0; snap = 1'b0; rd_en = 1'b0; rd_addr = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("reset rd_valid", 64'(rd_valid), 64'd0);
        check("reset rd_data", 64'(rd_data), 64'd0);
        check("reset rd_err", 64'(rd_err), 64'd0);
        check("reset ovf", 64'(ovf), 64'd0);
        check("reset frozen", 64'(frozen), 64'd0);

        // 1: ten counted cycles, then snap and back-to-back table reads
        for (int c = 0; c < 10; c++) begin
            cnt_en = 1'b1;
            evt    = {p3[c], 1'b0, 1'b0, p0[c]};
            tick();
        end
        cnt_en = 1'b0;
        evt    = '0;
        pulse_snap();
        for (int k = 0; k < 8; k++) begin
            rd_en   = 1'b1;
            rd_addr = vecs[k].addr;
            tick();
            check($sformatf("vec%0d valid", k), 64'(rd_valid), 64'd1);
            check($sformatf("vec%0d data", k), 64'(rd_data), 64'(vecs[k].data));
            check($sformatf("vec%0d err", k), 64'(rd_err), 64'(vecs[k].err));
        end
        rd_en = 1'b0;
        tick();
        check("vec valid drop", 64'(rd_valid), 64'd0);

        // 2: overflow just below the top of each counter width
        pulse_clear();
        force dut.cnt_q = {64'h0, 64'h0, 64'h0000_00AB_FFFF_FFFF,
                           64'hFFFF_FFFF_FFFF_FFFE, 64'h0};
        force dut_w.cnt_q = {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0};
        force dut_s.cnt_q = {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0};
        #1;
        release dut.cnt_q;
        release dut_w.cnt_q;
        release dut_s.cnt_q;
        cnt_en = 1'b1;
        evt = 4'b0011;
        tick();
        evt = 4'b0001;
        tick();
        check("wrap ovf w", 64'(ovf_w), 64'b00010);
        check("sat ovf s", 64'(ovf_s), 64'b00010);
        check("wrap ovf 64", 64'(ovf), 64'b00010);
        tick();
        cnt_en = 1'b0;
        evt = '0;
        check("sat ovf sticky", 64'(ovf_s), 64'b00010);
        pulse_snap();
        rd_all(4'd1, 1'b0);
        check("ch1 lo 64", 64'(rd_data), 64'd1);
        check("ch1 lo w", 64'(rd_data_w), 64'd1);
        check("ch1 lo s", 64'(rd_data_s), 64'hFFFF_FFFF);
        rd_all(4'd1, 1'b1);
        check("ch1 hi 64", 64'(rd_data), 64'd0);
        check("ch1 hi s", 64'(rd_data_s), 64'd0);
        rd_all(4'd2, 1'b0);
        check("ch2 lo 64", 64'(rd_data), 64'd0);
        check("ch2 lo w", 64'(rd_data_w), 64'd1);
        rd_all(4'd2, 1'b1);
        check("ch2 hi 64", 64'(rd_data), 64'hAC);
        check("ch2 hi w", 64'(rd_data_w), 64'd0);
        rd_all(4'd0, 1'b0);
        check("cycles w", 64'(rd_data_w), 64'd3);
        check("cycles 64", 64'(rd_data), 64'd3);

        // 3: halt freezes, clear resumes
        pulse_clear();
        check("clear ovf 64", 64'(ovf), 64'd0);
        check("clear ovf w", 64'(ovf_w), 64'd0);
        check("clear ovf s", 64'(ovf_s), 64'd0);
        cnt_en = 1'b1;
        evt = 4'b1111;
        for (int c = 0; c < 20; c++) tick();
        cnt_en = 1'b0;
        halt = 1'b1;
        tick();
        check("halt frozen", 64'(frozen), 64'd1);
        cnt_en = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        check("still frozen", 64'(frozen), 64'd1);
        halt = 1'b0;
        cnt_en = 1'b0;
        pulse_snap();
        rd_chk("frozen cycles", 4'd0, 1'b0, 32'd20, 1'b0);
        rd_chk("frozen ch3", 4'd3, 1'b0, 32'd20, 1'b0);
        cnt_en = 1'b1;
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        check("clear unfreezes", 64'(frozen), 64'd0);
        evt = 4'b0001;
        for (int c = 0; c < 3; c++) tick();
        cnt_en = 1'b0;
        evt = '0;
        pulse_snap();
        rd_chk("resume cycles", 4'd0, 1'b0, 32'd3, 1'b0);
        rd_chk("resume ch1", 4'd1, 1'b0, 32'd3, 1'b0);
        rd_chk("resume ch2", 4'd2, 1'b0, 32'd0, 1'b0);
        halt = 1'b1;
        cnt_clear = 1'b1;
        tick();
        halt = 1'b0;
        cnt_clear = 1'b0;
        check("halt+clear stays run", 64'(frozen), 64'd0);

        // 4: event, clear and snap together
        cnt_en = 1'b1;
        evt = 4'b0010;
        for (int c = 0; c < 7; c++) tick();
        cnt_clear = 1'b1;
        snap = 1'b1;
        tick();
        cnt_clear = 1'b0;
        snap = 1'b0;
        cnt_en = 1'b0;
        evt = '0;
        check("clear+snap ovf", 64'(ovf), 64'd0);
        rd_chk("shadow pre-clear ch2", 4'd2, 1'b0, 32'd7, 1'b0);
        pulse_snap();
        rd_chk("live ch2 dropped", 4'd2, 1'b0, 32'd0, 1'b0);
        rd_chk("live cycles cleared", 4'd0, 1'b0, 32'd0, 1'b0);

        // 5: out-of-range read, read racing a snap
        rd_chk("idx NUM_EVT+1", 4'(NUM_EVT + 1), 1'b0, 32'd0, 1'b1);
        rd_chk("idx NUM_EVT+1 hi", 4'(NUM_EVT + 1), 1'b1, 32'd0, 1'b1);
        cnt_en = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        cnt_en = 1'b0;
        snap = 1'b1;
        rd_chk("read with snap old", 4'd0, 1'b0, 32'd0, 1'b0);
        snap = 1'b0;
        rd_chk("read after snap", 4'd0, 1'b0, 32'd5, 1'b0);

        // 6: reset during a pending read with live state
        force dut.cnt_q = {64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
        #1;
        release dut.cnt_q;
        cnt_en = 1'b1;
        evt = 4'b0001;
        tick();
        evt = '0;
        check("pre-reset ovf", 64'(ovf), 64'b00010);
        tick();
        tick();
        cnt_en = 1'b0;
        pulse_snap();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        check("pre-reset frozen", 64'(frozen), 64'd1);
        rd_en = 1'b1;
        rd_addr = {4'd0, 1'b0};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_en = 1'b0;
        check("rst rd_valid", 64'(rd_valid), 64'd0);
        check("rst rd_data", 64'(rd_data), 64'd0);
        check("rst ovf", 64'(ovf), 64'd0);
        check("rst frozen", 64'(frozen), 64'd0);
        rd_chk("rst shadow cycles", 4'd0, 1'b0, 32'd0, 1'b0);
        pulse_snap();
        rd_chk("rst live cycles", 4'd0, 1'b0, 32'd0, 1'b0);
        rd_chk("rst live ch1", 4'd1, 1'b0, 32'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
